// File: rtl/piano_pkg.sv
// piano_pkg
// Shared definitions for the piano_voice tone generator: default
// half-period table (C4..C5 at a 100 MHz clock), default widths and the
// voice state enumeration.
// Ports: none (package).
package piano_pkg;

  localparam int NUM_KEYS_DEFAULT = 8;
  localparam int CNT_W_DEFAULT    = 18;

  // Entry i sits at bits [i*CNT_W +: CNT_W]; key 0 (C4) is the lowest slice.
  localparam logic [NUM_KEYS_DEFAULT*CNT_W_DEFAULT-1:0] HALF_DEFAULT = {
    18'd95557,  18'd101239, 18'd113636, 18'd127551,
    18'd143172, 18'd151685, 18'd170265, 18'd191110
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } voice_state_t;

endpackage

// File: rtl/piano_voice_key_select.sv
// key_select
// Synchronises the raw key switches, detects their edges and keeps the
// selected key register (sel_idx/sel_vld) according to the priority mode.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   sw          raw asynchronous key switches, bit i = key i
//   mode        0 = highest pressed index wins, 1 = last pressed wins
//   sel_idx     index of the selected key
//   sel_vld     at least one synchronised key is pressed
module key_select
  import piano_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                mode,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                sel_vld
);

  logic [NUM_KEYS-1:0] sw_m;
  logic [NUM_KEYS-1:0] sw_s;
  logic [NUM_KEYS-1:0] sw_p;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic                sel_fell;
  logic [IDX_W-1:0]    sel_idx_next;

  function automatic logic [IDX_W-1:0] highest(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Two-stage synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_m <= '0;
      sw_s <= '0;
      sw_p <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      sw_p <= sw_s;
    end
  end

  assign rise = sw_s & ~sw_p;
  assign fall = ~sw_s & sw_p;

  // Loop compare instead of fall[sel_idx] so an index past NUM_KEYS-1 is
  // never used as a bit select.
  always_comb begin
    sel_fell = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel_idx == IDX_W'(i) && fall[i]) sel_fell = 1'b1;
    end
  end

  // With no key held the index keeps its old value; it is only consumed
  // while sel_vld is high. Simultaneous presses resolve to the highest index.
  always_comb begin
    sel_idx_next = sel_idx;
    if (!mode) begin
      if (|sw_s) sel_idx_next = highest(sw_s);
    end else if (|rise) begin
      sel_idx_next = highest(rise);
    end else if (sel_fell && (|sw_s)) begin
      sel_idx_next = highest(sw_s);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_idx <= '0;
      sel_vld <= 1'b0;
    end else begin
      sel_idx <= sel_idx_next;
      sel_vld <= |sw_s;
    end
  end

endmodule

// File: rtl/piano_voice.sv
// piano_voice
// Single-voice square-wave tone generator. One shared half-period counter
// is reloaded from a per-key table at every waveform edge, so retuning,
// key changes and octave changes only ever take effect on a boundary.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   sw          raw asynchronous key switches, bit i = key i
//   MODE        0 = fixed priority (highest index), 1 = last-pressed priority
//   OCT         octave up-shift applied to the table entry (clamped to 1)
//   FREQ        square-wave tone output
//   NOTE_ON     high while the voice is in PLAY
//   NOTE_IDX    key index whose half period is currently loaded
module piano_voice
  import piano_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter logic [NUM_KEYS*CNT_W-1:0] HALF_TABLE = piano_pkg::HALF_DEFAULT,
  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                MODE,
  input  logic [1:0]          OCT,
  output logic                FREQ,
  output logic                NOTE_ON,
  output logic [IDX_W-1:0]    NOTE_IDX
);

  voice_state_t     state;
  voice_state_t     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             freq_next;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic [CNT_W-1:0] half_raw;
  logic [CNT_W-1:0] half_eff;
  logic [CNT_W-1:0] reload;

  key_select #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_key_select (
    .CLK     (CLK),
    .RESET   (RESET),
    .sw      (sw),
    .mode    (MODE),
    .sel_idx (sel_idx),
    .sel_vld (sel_vld)
  );

  // Half period of the selected key after the octave shift. A shift that
  // underflows to zero is clamped to one cycle; the counter holds half-1.
  always_comb begin
    half_raw = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel_idx == IDX_W'(i)) half_raw = HALF_TABLE[i*CNT_W +: CNT_W];
    end
    half_eff = half_raw >> OCT;
    if (half_eff == '0) half_eff = CNT_W'(1);
    reload = half_eff - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      FREQ     <= 1'b0;
      NOTE_IDX <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      FREQ     <= freq_next;
      NOTE_IDX <= idx_next;
    end
  end

  // Selection and OCT are sampled only when a half period starts, so every
  // half period runs to completion before the tone or silence changes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    freq_next  = FREQ;
    idx_next   = NOTE_IDX;
    case (state)
      IDLE: begin
        freq_next = 1'b0;
        if (sel_vld) begin
          cnt_next   = reload;
          freq_next  = 1'b1;
          idx_next   = sel_idx;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (sel_vld) begin
          cnt_next  = reload;
          freq_next = ~FREQ;
          idx_next  = sel_idx;
        end else begin
          freq_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        freq_next  = 1'b0;
      end
    endcase
  end

  assign NOTE_ON = (state == PLAY);

endmodule

// File: tb/tb_piano_voice.sv
// tb_piano_voice
// Self-checking bench for piano_voice with a 3-key table (3, 5, 8 cycles).
// A behavioural model tracks the tone as absolute boundary times and is
// compared against FREQ/NOTE_ON/NOTE_IDX every cycle; directed scenarios add
// hand-computed literal expectations, followed by a randomized phase.
module tb_piano_voice;

  localparam int NK = 3;
  localparam int CW = 18;
  localparam logic [NK*CW-1:0] TABLE = {18'd8, 18'd5, 18'd3};

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] sw;
  logic       MODE;
  logic [1:0] OCT;
  logic       FREQ;
  logic       NOTE_ON;
  logic [1:0] NOTE_IDX;

  int checks = 0;
  int errors = 0;

  piano_voice #(
    .NUM_KEYS   (NK),
    .CNT_W      (CW),
    .HALF_TABLE (TABLE)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .sw       (sw),
    .MODE     (MODE),
    .OCT      (OCT),
    .FREQ     (FREQ),
    .NOTE_ON  (NOTE_ON),
    .NOTE_IDX (NOTE_IDX)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  int         half_tab [3] = '{3, 5, 8};
  logic [2:0] seen1, seen2, seen3;
  bit         m_vld;
  int         m_sel;
  bit         m_play;
  bit         m_level;
  int         m_idx;
  longint     m_cyc;
  longint     m_bound;

  function automatic int halfOf(input int k, input int oct);
    int h;
    h = half_tab[k] >> oct;
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int topBit(input logic [2:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic modelEdge();
    logic [2:0] s, p, rise, fall;
    m_cyc++;
    if (RESET) begin
      seen1 = '0; seen2 = '0; seen3 = '0;
      m_vld = 0; m_sel = 0; m_play = 0; m_level = 0; m_idx = 0;
    end else begin
      if (!m_play) begin
        if (m_vld) begin
          m_play  = 1;
          m_level = 1;
          m_idx   = m_sel;
          m_bound = m_cyc + halfOf(m_sel, int'(OCT));
        end
      end else if (m_cyc == m_bound) begin
        if (m_vld) begin
          m_level = !m_level;
          m_idx   = m_sel;
          m_bound = m_cyc + halfOf(m_sel, int'(OCT));
        end else begin
          m_level = 0;
          m_play  = 0;
        end
      end
      s = seen2;
      p = seen3;
      rise = s & ~p;
      fall = ~s & p;
      if (!MODE) begin
        if (s != 0) m_sel = topBit(s);
      end else if (rise != 0) begin
        m_sel = topBit(rise);
      end else if (fall[m_sel] && s != 0) begin
        m_sel = topBit(s);
      end
      m_vld = (s != 0);
      seen3 = seen2;
      seen2 = seen1;
      seen1 = sw;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] s, input logic m,
                               input logic [1:0] o, input logic r);
    sw    = s;
    MODE  = m;
    OCT   = o;
    RESET = r;
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    checkOutput("model_freq", int'(FREQ), int'(m_level));
    checkOutput("model_note_on", int'(NOTE_ON), int'(m_play));
    checkOutput("model_note_idx", int'(NOTE_IDX), m_idx);
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  // Length in cycles of the next complete FREQ level; -1 on timeout.
  task automatic measureRun(output int len);
    logic start;
    int   n;
    start = FREQ;
    n = 0;
    while (FREQ == start && n < 40) begin
      stepCycle();
      n++;
    end
    if (n >= 40) begin
      len = -1;
      return;
    end
    start = FREQ;
    len = 0;
    while (FREQ == start && len < 40) begin
      stepCycle();
      len++;
    end
    if (len >= 40) len = -1;
  endtask

  initial begin
    int len;
    int n;
    m_cyc = 0;
    m_bound = 0;
    seen1 = '0; seen2 = '0; seen3 = '0;
    m_vld = 0; m_sel = 0; m_play = 0; m_level = 0; m_idx = 0;

    // Reset and silence
    applyStimulus(3'b000, 1'b0, 2'd0, 1'b1);
    runCycles(3);
    checkOutput("reset_freq", int'(FREQ), 0);
    checkOutput("reset_note_on", int'(NOTE_ON), 0);
    checkOutput("reset_note_idx", int'(NOTE_IDX), 0);
    applyStimulus(3'b000, 1'b0, 2'd0, 1'b0);
    runCycles(20);
    checkOutput("idle_freq", int'(FREQ), 0);
    checkOutput("idle_note_on", int'(NOTE_ON), 0);

    // Key0 press: FREQ rises after the fourth edge, half period 3
    applyStimulus(3'b001, 1'b0, 2'd0, 1'b0);
    runCycles(3);
    checkOutput("press_latency_low", int'(FREQ), 0);
    runCycles(1);
    checkOutput("press_freq_high", int'(FREQ), 1);
    checkOutput("press_note_on", int'(NOTE_ON), 1);
    checkOutput("press_note_idx", int'(NOTE_IDX), 0);
    runCycles(2);
    checkOutput("key0_still_high", int'(FREQ), 1);
    runCycles(1);
    checkOutput("key0_first_toggle", int'(FREQ), 0);

    // Add key1 mid half period; fixed priority moves to key1 (half 5)
    runCycles(1);
    applyStimulus(3'b011, 1'b0, 2'd0, 1'b0);
    runCycles(20);
    checkOutput("retune_note_idx", int'(NOTE_IDX), 1);
    measureRun(len);
    checkOutput("key1_half", len, 5);

    // Release all
    applyStimulus(3'b000, 1'b0, 2'd0, 1'b0);
    runCycles(20);
    checkOutput("release_note_on", int'(NOTE_ON), 0);
    checkOutput("release_freq", int'(FREQ), 0);

    // Last-pressed priority: key2, then key0, then release key0
    applyStimulus(3'b000, 1'b1, 2'd0, 1'b0);
    runCycles(5);
    applyStimulus(3'b100, 1'b1, 2'd0, 1'b0);
    runCycles(20);
    checkOutput("lp_key2_idx", int'(NOTE_IDX), 2);
    measureRun(len);
    checkOutput("lp_key2_half", len, 8);
    applyStimulus(3'b101, 1'b1, 2'd0, 1'b0);
    runCycles(30);
    checkOutput("lp_key0_idx", int'(NOTE_IDX), 0);
    measureRun(len);
    checkOutput("lp_key0_half", len, 3);
    applyStimulus(3'b100, 1'b1, 2'd0, 1'b0);
    runCycles(30);
    checkOutput("lp_fallback_idx", int'(NOTE_IDX), 2);
    measureRun(len);
    checkOutput("lp_fallback_half", len, 8);

    // Octave shift: 8>>2 = 2, then key0 with 3>>3 clamped to 1
    applyStimulus(3'b100, 1'b1, 2'd2, 1'b0);
    runCycles(20);
    measureRun(len);
    checkOutput("oct2_half", len, 2);
    applyStimulus(3'b001, 1'b1, 2'd3, 1'b0);
    runCycles(10);
    checkOutput("oct3_idx", int'(NOTE_IDX), 0);
    measureRun(len);
    checkOutput("oct3_clamped_half", len, 1);

    // Simultaneous press, then release-all plus new press with no gap
    applyStimulus(3'b000, 1'b1, 2'd0, 1'b0);
    runCycles(20);
    applyStimulus(3'b011, 1'b1, 2'd0, 1'b0);
    runCycles(20);
    checkOutput("simul_idx", int'(NOTE_IDX), 1);
    applyStimulus(3'b100, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      checkOutput("no_gap_note_on", int'(NOTE_ON), 1);
    end

    // Release while FREQ is high
    n = 0;
    while (FREQ != 1'b1 && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("wait_freq_high", int'(FREQ), 1);
    applyStimulus(3'b000, 1'b1, 2'd0, 1'b0);
    runCycles(15);
    checkOutput("release_high_freq", int'(FREQ), 0);
    checkOutput("release_high_note_on", int'(NOTE_ON), 0);

    // Reset mid-note
    applyStimulus(3'b001, 1'b0, 2'd0, 1'b0);
    runCycles(10);
    checkOutput("pre_reset_note_on", int'(NOTE_ON), 1);
    applyStimulus(3'b001, 1'b0, 2'd0, 1'b1);
    runCycles(1);
    checkOutput("midnote_reset_freq", int'(FREQ), 0);
    checkOutput("midnote_reset_note_on", int'(NOTE_ON), 0);
    applyStimulus(3'b000, 1'b0, 2'd0, 1'b0);
    runCycles(5);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] s;
      logic       m;
      logic [1:0] o;
      logic       r;
      s = sw; m = MODE; o = OCT; r = 1'b0;
      if ($urandom_range(7) == 0) s = 3'($urandom_range(7));
      if ($urandom_range(63) == 0) m = ~m;
      if ($urandom_range(63) == 0) o = 2'($urandom_range(3));
      if ($urandom_range(199) == 0) r = 1'b1;
      applyStimulus(s, m, o, r);
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
